rice_core_div_unit: RTL and testbench
=====================================

Name: rice_core_div_unit

Overview:
- Iterative restoring divider for the RICE core execute stage; implements RV32M/RV64M DIV, DIVU, REM and REMU.
- Replaces fixed-width combinational division with a width-parametrised, multi-cycle unit using a valid/ready handshake.
- Produces RISC-V-compliant results for divide-by-zero and signed overflow.
- Operation encoding is rice_core_div_operation from rice_core_pkg.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 8..64.
- COUNTER_WIDTH, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  reset, synchronous, active-high.
- i_flush  input  1  abort in-flight operation (pipeline flush/trap).
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request.
- i_op  input  4  rice_core_div_operation {div, divu, rem, remu}.
- i_rs1  input  XLEN  dividend.
- i_rs2  input  XLEN  divisor.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  XLEN  quotient or remainder.

Behaviour:
- Reset: state IDLE, o_ready=1, o_valid=0, o_result=0, all internal registers 0. Reset has priority over flush and handshakes.
- States:
  - IDLE: o_ready=1. Accept when i_valid && o_ready. Latch the operation, operand sign flags, absolute values (signed ops only) and special-case flags. Go to BUSY, counter=XLEN-1.
  - BUSY: each cycle, shift remainder:dividend left by 1; subtract divisor if remainder >= divisor; quotient bit = 1 on subtract. Counter decrements; at 0, go to DONE.
  - DONE: o_valid=1. o_result holds stable until i_valid... until i_ready. On i_ready, go to IDLE.
- o_ready is high only in IDLE; a new request is never accepted in the same cycle a result retires. o_ready rises the cycle after the handshake.
- Latency: request accepted in cycle 0 gives o_valid first high in cycle XLEN+1 (1 load cycle plus XLEN iterations).
- Sign fix, registered on entry to DONE:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (rs2==0):
  - div/divu quotient = all ones.
  - rem/remu result = rs1 unmodified.
- Signed overflow (div/rem, rs1 = 1<<(XLEN-1), rs2 = all ones): quotient = rs1, remainder = 0.
- i_op priority: div > divu > rem > remu. i_op==0 is accepted and yields o_result=0 at normal latency.
- i_flush:
  - In BUSY or DONE: next state IDLE, o_valid=0 the following cycle, result discarded.
  - In IDLE with i_valid: nothing is accepted.
  - Flush in the same cycle as a result handshake: result counts as consumed; state IDLE.
- Inputs are sampled only on accept; changes to i_rs1/i_rs2/i_op while BUSY have no effect.
- Back-pressure: in DONE with i_ready=0, state, o_valid and o_result hold indefinitely.

Optional Feature:
- Macro: RICE_CORE_DIV_FAST_PATH_EN.
- Defined: divide-by-zero and signed-overflow requests skip BUSY, going IDLE→DONE directly. o_valid is high in cycle 1 after accept.
- Defined, additionally: when unsigned |rs1| < |rs2| (including rs1==0), DONE is also reached in cycle 1. Quotient = 0; remainder = rs1.
- Undefined: all requests take the full XLEN+1 cycles; results are identical.

Test Plan:
- XLEN=32, div rs1=0xFFFFFFF9 (-7), rs2=2 → o_result=0xFFFFFFFD, o_valid in cycle 33. Same operands with rem → 0xFFFFFFFF.
- divu 100/7 → 14; remu 100/7 → 2. XLEN=8 build: divu 0xFF/0x10 → 0x0F with o_valid in cycle 9.
- divu 0x1234/0 → 0xFFFFFFFF; remu 0x1234/0 → 0x1234. Latency is 33 without the macro, 1 with it.
- div 0x80000000/0xFFFFFFFF → 0x80000000; rem with the same operands → 0.
- Result ready, i_ready held low 5 cycles → o_valid=1, o_result stable, o_ready=0 throughout. i_ready=1 → o_valid=0 and o_ready=1 next cycle. Back-to-back request is accepted one cycle later.
- Flush in iteration 10 → o_ready=1 next cycle, o_valid never asserts. Then i_rst mid-BUSY → all outputs at reset values next cycle.

Source files
------------

// File: rtl/rice_core_div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes on both sides.
// Define RICE_CORE_DIV_FAST_PATH_EN to finish trivial requests one cycle after accept.
module rice_core_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result
);

   localparam int unsigned COUNTER_WIDTH = $clog2(XLEN);
   localparam logic [XLEN-1:0] SignMin = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]          dvd_q, dvd_d;
   logic [XLEN-1:0]          dsr_q, dsr_d;
   logic [XLEN-1:0]          rem_q, rem_d;
   logic [XLEN-1:0]          rs1_q, rs1_d;
   logic [XLEN-1:0]          result_q, result_d;
   logic                     sgn_q, sgn_d;
   logic                     rem_sel_q, rem_sel_d;
   logic                     nop_q, nop_d;
   logic                     div0_q, div0_d;
   logic                     ovf_q, ovf_d;
   logic                     q_neg_q, q_neg_d;
   logic                     r_neg_q, r_neg_d;

   // Request decode; i_op is {div, divu, rem, remu} with div taking priority.
   logic            in_sgn, in_rem_sel, in_nop, in_div0, in_ovf, in_q_neg, in_r_neg;
   logic [XLEN-1:0] in_a, in_b;
   logic            accept, fast_go;

   assign in_nop     = (i_op == 4'b0000);
   assign in_sgn     = i_op[3] | ((i_op[3:2] == 2'b00) & i_op[1]);
   assign in_rem_sel = (i_op[3:2] == 2'b00) & (i_op[1] | i_op[0]);
   assign in_a       = (in_sgn & i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
   assign in_b       = (in_sgn & i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
   assign in_div0    = (i_rs2 == '0);
   assign in_ovf     = in_sgn & (i_rs1 == SignMin) & (&i_rs2);
   assign in_q_neg   = in_sgn & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
   assign in_r_neg   = in_sgn & i_rs1[XLEN-1];
   assign accept     = i_valid & o_ready & ~i_flush;

`ifdef RICE_CORE_DIV_FAST_PATH_EN
   assign fast_go = ~in_nop & (in_div0 | in_ovf | (in_a < in_b));
`else
   assign fast_go = 1'b0;
`endif

   // One restoring step on the remainder:dividend pair.
   logic [XLEN:0]   rem_shift, rem_sub;
   logic            rem_ge;
   logic [XLEN-1:0] rem_nxt, dvd_nxt;

   assign rem_shift = {rem_q, dvd_q[XLEN-1]};
   assign rem_sub   = rem_shift - {1'b0, dsr_q};
   assign rem_ge    = (rem_shift >= {1'b0, dsr_q});
   assign rem_nxt   = rem_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
   assign dvd_nxt   = {dvd_q[XLEN-2:0], rem_ge};

   function automatic logic [XLEN-1:0] finalize(
      input logic            nop,
      input logic            rem_sel,
      input logic            div0,
      input logic            ovf,
      input logic            q_neg,
      input logic            r_neg,
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r,
      input logic [XLEN-1:0] rs1
   );
      logic [XLEN-1:0] res;
      if (nop) begin
         res = '0;
      end else if (div0) begin
         res = rem_sel ? rs1 : '1;
      end else if (ovf) begin
         res = rem_sel ? '0 : rs1;
      end else if (rem_sel) begin
         res = r_neg ? -r : r;
      end else begin
         res = q_neg ? -q : q;
      end
      return res;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      rem_d     = rem_q;
      rs1_d     = rs1_q;
      result_d  = result_q;
      sgn_d     = sgn_q;
      rem_sel_d = rem_sel_q;
      nop_d     = nop_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d     = COUNTER_WIDTH'(XLEN - 1);
               dvd_d     = in_a;
               dsr_d     = in_b;
               rem_d     = '0;
               rs1_d     = i_rs1;
               sgn_d     = in_sgn;
               rem_sel_d = in_rem_sel;
               nop_d     = in_nop;
               div0_d    = in_div0;
               ovf_d     = in_ovf;
               q_neg_d   = in_q_neg;
               r_neg_d   = in_r_neg;
               if (fast_go) begin
                  // Small dividend: quotient 0, remainder |rs1| before sign fix.
                  state_d  = StDone;
                  result_d = finalize(in_nop, in_rem_sel, in_div0, in_ovf, in_q_neg,
                                      in_r_neg, '0, in_a, i_rs1);
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (i_flush) begin
               state_d = StIdle;
            end else begin
               dvd_d = dvd_nxt;
               rem_d = rem_nxt;
               cnt_d = cnt_q - COUNTER_WIDTH'(1);
               if (cnt_q == '0) begin
                  state_d  = StDone;
                  result_d = finalize(nop_q, rem_sel_q, div0_q, ovf_q, q_neg_q, r_neg_q,
                                      dvd_nxt, rem_nxt, rs1_q);
               end
            end
         end
         StDone: begin
            if (i_flush || i_ready) begin
               state_d  = StIdle;
               result_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         rs1_q     <= '0;
         result_q  <= '0;
         sgn_q     <= 1'b0;
         rem_sel_q <= 1'b0;
         nop_q     <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         rem_q     <= rem_d;
         rs1_q     <= rs1_d;
         result_q  <= result_d;
         sgn_q     <= sgn_d;
         rem_sel_q <= rem_sel_d;
         nop_q     <= nop_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
      end
   end

   assign o_ready  = (state_q == StIdle);
   assign o_valid  = (state_q == StDone);
   assign o_result = result_q;

endmodule

// File: tb/tb_rice_core_div_unit.sv
// Scoreboarded bench for rice_core_div_unit at XLEN=32: directed vectors, back-pressure,
// flush and reset. Expected latencies follow RICE_CORE_DIV_FAST_PATH_EN when defined.
module tb_rice_core_div_unit;

   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_REM  = 4'b0010;
   localparam logic [3:0] OP_REMU = 4'b0001;
   localparam int         NL      = 33;
`ifdef RICE_CORE_DIV_FAST_PATH_EN
   localparam int         FL      = 1;
`else
   localparam int         FL      = 33;
`endif

   logic        clk = 1'b0;
   logic        i_rst, i_flush, i_valid, i_ready;
   logic [3:0]  i_op;
   logic [31:0] i_rs1, i_rs2;
   logic        o_ready, o_valid;
   logic [31:0] o_result;

   rice_core_div_unit #(.XLEN(32)) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_flush  (i_flush),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_rs1    (i_rs1),
      .i_rs2    (i_rs2),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      int          id;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_id = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input int lat);
      vecs.push_back('{op: op, a: a, b: b, res: res, lat: lat});
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] res, input int lat,
                        output int acc);
      int waited = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_op    = op;
      i_rs1   = a;
      i_rs2   = b;
      while (!o_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      acc = cyc;
      if (!o_ready) begin
         chk("issue_timeout", 64'(o_ready), 64'd1);
         i_valid = 1'b0;
      end else begin
         if (push) begin
            exp_q.push_back('{res: res, lat: lat, acc: cyc, id: n_id});
            n_id++;
         end
         @(posedge clk);
         #1;
         i_valid = 1'b0;
         i_op    = OP_REMU;
         i_rs1   = 32'hDEAD_BEEF;
         i_rs2   = 32'h0;
      end
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && o_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!o_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(o_valid), 64'd1);
   endtask

   task automatic no_valid(input string name, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_valid) seen = 1'b1;
      end
      chk(name, 64'(seen), 64'd0);
   endtask

   // Monitor: compare each presented result against the head of the scoreboard.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (i_rst) begin
            prev = 1'b0;
         end else begin
            if (o_valid && !prev) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_valid: got result %0h required no output", o_result);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("vec%0d_result", e.id), 64'(o_result), 64'(e.res));
                  chk($sformatf("vec%0d_latency", e.id), 64'(cyc - e.acc), 64'(e.lat));
               end
            end
            prev = o_valid;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      int r;
      i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_op = 4'b0; i_rs1 = '0; i_rs2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 64'(o_ready), 64'd1);
      chk("reset_valid", 64'(o_valid), 64'd0);
      chk("reset_result", 64'(o_result), 64'd0);
      @(negedge clk);
      i_rst = 1'b0;

      add(OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, NL);
      add(OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, NL);
      add(OP_DIVU, 32'd100,       32'd7,        32'd14,        NL);
      add(OP_REMU, 32'd100,       32'd7,        32'd2,         NL);
      add(OP_DIVU, 32'h1234,      32'd0,        32'hFFFF_FFFF, FL);
      add(OP_REMU, 32'h1234,      32'd0,        32'h1234,      FL);
      add(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FL);
      add(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        FL);
      add(OP_DIVU, 32'hFF,        32'h10,       32'h0F,        NL);
      add(4'b0000, 32'd5,         32'd3,        32'h0,         NL);
      add(OP_DIVU, 32'd3,         32'd10,       32'd0,         FL);
      add(OP_REMU, 32'd3,         32'd10,       32'd3,         FL);
      add(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NL);
      add(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,        NL);
      add(OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        NL);
      add(OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, NL);
      add(4'b1111, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, NL);
      add(4'b0011, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, NL);
      add(4'b0110, 32'd100,       32'd7,        32'd14,        NL);
      add(OP_DIV,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, FL);
      add(OP_REM,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, FL);
      add(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        NL);
      add(OP_REM,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFD, FL);
      add(OP_DIV,  32'hFFFF_FFFD, 32'd5,        32'd0,         FL);

      foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].lat, acc);
      drain();

      // Back-pressure, then retire and a back-to-back request.
      i_ready = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, NL, acc);
      wait_valid("bp_valid_seen");
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_hold", 64'(o_valid), 64'd1);
         chk("bp_result_hold", 64'(o_result), 64'd14);
         chk("bp_ready_low", 64'(o_ready), 64'd0);
         @(negedge clk);
      end
      i_ready = 1'b1;
      r = cyc;
      @(posedge clk);
      #1;
      chk("retire_valid_low", 64'(o_valid), 64'd0);
      chk("retire_ready_high", 64'(o_ready), 64'd1);
      issue(OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, NL, acc);
      chk("b2b_accept_gap", 64'(acc - r), 64'd1);
      drain();

      // Flush coinciding with the result handshake.
      i_ready = 1'b0;
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, NL, acc);
      wait_valid("fh_valid_seen");
      i_flush = 1'b1;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("fh_ready", 64'(o_ready), 64'd1);
      chk("fh_valid", 64'(o_valid), 64'd0);
      @(negedge clk);
      i_flush = 1'b0;

      // Flush during iteration 10.
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, NL, acc);
      while (cyc < acc + 10) @(negedge clk);
      i_flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_busy_ready", 64'(o_ready), 64'd1);
      chk("flush_busy_valid", 64'(o_valid), 64'd0);
      @(negedge clk);
      i_flush = 1'b0;
      no_valid("flush_busy_no_result", 40);

      // Flush in IDLE blocks acceptance.
      @(negedge clk);
      i_valid = 1'b1; i_flush = 1'b1; i_op = OP_DIVU; i_rs1 = 32'd100; i_rs2 = 32'd7;
      @(posedge clk);
      #1;
      chk("flush_idle_ready", 64'(o_ready), 64'd1);
      @(negedge clk);
      i_valid = 1'b0; i_flush = 1'b0;
      no_valid("flush_idle_no_result", 40);

      // Reset mid-BUSY.
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, NL, acc);
      repeat (5) @(negedge clk);
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_busy_ready", 64'(o_ready), 64'd1);
      chk("rst_busy_valid", 64'(o_valid), 64'd0);
      chk("rst_busy_result", 64'(o_result), 64'd0);
      @(negedge clk);
      i_rst = 1'b0;

      // Reset while a result is held.
      i_ready = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, NL, acc);
      wait_valid("rst_done_valid_seen");
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_done_valid", 64'(o_valid), 64'd0);
      chk("rst_done_result", 64'(o_result), 64'd0);
      chk("rst_done_ready", 64'(o_ready), 64'd1);
      @(negedge clk);
      i_rst = 1'b0;
      i_ready = 1'b1;

      issue(OP_REMU, 32'hFF, 32'h10, 1'b1, 32'h0F, NL, acc);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
